// File: rtl/prog_loader_if.sv
// Serial program link plus the RAM write port and status outputs of the loader.
// master is the loader's view; slave is the pad/CPU side.
interface prog_loader_if #(
    parameter int ADDR_W = 4
);
    logic              spi_sclk;
    logic              spi_mosi;
    logic              spi_cs_n;
    logic              load_ram;
    logic [ADDR_W-1:0] load_addr;
    logic [7:0]        load_data;
    logic              cpu_run_n;
    logic              load_done;
    logic              load_err;
    logic [ADDR_W:0]   byte_cnt;

    modport master (
        input  spi_sclk, spi_mosi, spi_cs_n,
        output load_ram, load_addr, load_data, cpu_run_n, load_done, load_err, byte_cnt
    );

    modport slave (
        output spi_sclk, spi_mosi, spi_cs_n,
        input  load_ram, load_addr, load_data, cpu_run_n, load_done, load_err, byte_cnt
    );
endinterface

// File: rtl/prog_loader.sv
// prog_loader: SPI mode-0 program image receiver; writes the CPU program RAM and holds the CPU in reset until done.
// Latency: load_ram pulses one clock after the synchronized 8th sclk rise. PROG_LOADER_CHECKSUM_EN adds a trailing checksum byte.
// Backpressure: none; the serial link has no flow control, sclk must stay at or below clock/4.
module prog_loader #(
    parameter int NUM_BYTES   = 16,
    parameter int ADDR_W      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clock,
    input  logic          cpu_reset,
    prog_loader_if.master bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, WRITE, DONE} state_t;

    localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W + 1)'(NUM_BYTES);

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic                   sclk_s;
    logic                   mosi_s;
    logic                   cs_s;
    logic                   sclk_prev;
    logic                   cs_prev;
    logic                   sclk_rise;
    logic                   cs_fall;

    state_t                 state;
    state_t                 state_nxt;
    logic [6:0]             shreg;
    logic [2:0]             bit_cnt;
    logic [7:0]             byte_nxt;
    logic [ADDR_W:0]        cnt_inc;

    logic                   wr_stb;
    logic [ADDR_W-1:0]      wr_addr;
    logic [7:0]             wr_data;
    logic                   run_n;
    logic                   done;
    logic                   err;
    logic [ADDR_W:0]        cnt;

    logic                   frame_start;
    logic                   shift_en;
    logic                   capture;
    logic                   write_end;
    logic                   set_err;
    logic                   enter_done;
    logic                   csum_phase;
    logic                   csum_ok;
    logic                   last_write;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign cs_fall   = cs_prev & ~cs_s;
    assign byte_nxt  = {shreg, mosi_s};
    assign cnt_inc   = cnt + 1'b1;

    always_ff @(posedge clock) begin
        if (!cpu_reset) begin
            sclk_sync <= '1;
            mosi_sync <= '0;
            cs_sync   <= '1;
            sclk_prev <= 1'b1;
            cs_prev   <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.spi_sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.spi_cs_n};
            sclk_prev <= sclk_s;
            cs_prev   <= cs_s;
        end
    end

`ifdef PROG_LOADER_CHECKSUM_EN
    // Running sum of bytes already written; the checksum byte itself is never stored.
    logic [7:0] csum;

    assign csum_phase = (cnt == LAST_CNT);
    assign csum_ok    = (8'(csum + byte_nxt) == 8'h00);
    assign last_write = 1'b0;

    always_ff @(posedge clock) begin
        if (!cpu_reset) begin
            csum <= 8'h00;
        end else if (state == IDLE || frame_start) begin
            csum <= 8'h00;
        end else if (write_end) begin
            csum <= csum + wr_data;
        end
    end
`else
    assign csum_phase = 1'b0;
    assign csum_ok    = 1'b0;
    assign last_write = (cnt_inc == LAST_CNT);
`endif

    always_ff @(posedge clock) begin
        if (!cpu_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        frame_start = 1'b0;
        shift_en    = 1'b0;
        capture     = 1'b0;
        write_end   = 1'b0;
        set_err     = 1'b0;
        enter_done  = 1'b0;
        case (state)
            IDLE: begin
                if (!cs_s) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                // A cs_n rise in the same cycle as an sclk rise drops the bit.
                if (cs_s) begin
                    state_nxt = IDLE;
                    set_err   = 1'b1;
                end else if (sclk_rise) begin
                    shift_en = 1'b1;
                    if (bit_cnt == 3'd7) begin
                        if (!csum_phase) begin
                            capture   = 1'b1;
                            state_nxt = WRITE;
                        end else if (csum_ok) begin
                            enter_done = 1'b1;
                            state_nxt  = DONE;
                        end else begin
                            set_err   = 1'b1;
                            state_nxt = IDLE;
                        end
                    end
                end
            end
            WRITE: begin
                write_end = 1'b1;
                if (last_write) begin
                    enter_done = 1'b1;
                    state_nxt  = DONE;
                end else begin
                    state_nxt = SHIFT;
                end
            end
            DONE: begin
                if (cs_fall) begin
                    frame_start = 1'b1;
                    state_nxt   = SHIFT;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!cpu_reset) begin
            shreg   <= '0;
            bit_cnt <= '0;
            wr_stb  <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            run_n   <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            cnt     <= '0;
        end else begin
            wr_stb <= capture;
            if (shift_en) begin
                shreg   <= byte_nxt[6:0];
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (capture) begin
                wr_data <= byte_nxt;
            end
            if (state == IDLE || frame_start) begin
                bit_cnt <= '0;
                cnt     <= '0;
                wr_addr <= '0;
            end
            // Address wraps to 0 after the last slot; it is reset before reuse.
            if (write_end) begin
                wr_addr <= wr_addr + 1'b1;
                cnt     <= cnt_inc;
                bit_cnt <= '0;
            end
            if (frame_start) begin
                err   <= 1'b0;
                done  <= 1'b0;
                run_n <= 1'b0;
            end
            if (set_err) begin
                err <= 1'b1;
            end
            if (enter_done) begin
                done  <= 1'b1;
                run_n <= 1'b1;
            end
        end
    end

    assign bus.load_ram  = wr_stb;
    assign bus.load_addr = wr_addr;
    assign bus.load_data = wr_data;
    assign bus.cpu_run_n = run_n;
    assign bus.load_done = done;
    assign bus.load_err  = err;
    assign bus.byte_cnt  = cnt;
endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: table of frames, hand-written corner sequences and random frames against an image-level model.
module tb_prog_loader;
    localparam int NB = 16;
    localparam int AW = 4;
    localparam int SS = 2;
`ifdef PROG_LOADER_CHECKSUM_EN
    localparam int FL = NB + 1;
`else
    localparam int FL = NB;
`endif

    logic clock = 1'b0;
    logic cpu_reset = 1'b0;
    prog_loader_if #(.ADDR_W(AW)) bus ();

    prog_loader #(.NUM_BYTES(NB), .ADDR_W(AW), .SYNC_STAGES(SS)) dut (
        .clock     (clock),
        .cpu_reset (cpu_reset),
        .bus       (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        int nbytes;
        int nbits;
        int pattern;
        int exp_wr;
        bit exp_done;
        bit exp_err;
        int exp_cnt;
    } vec_t;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] img [0:NB+1];
    int         wr_addr_q [$];
    int         wr_data_q [$];
    bit         m_done = 1'b0;
    bit         m_err = 1'b0;

    always @(negedge clock) begin
        if (cpu_reset === 1'b1 && bus.load_ram === 1'b1) begin
            wr_addr_q.push_back(int'(bus.load_addr));
            wr_data_q.push_back(int'(bus.load_data));
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_bits(input logic [7:0] b, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            bus.spi_sclk = 1'b0;
            bus.spi_mosi = b[7-i];
            cyc(4);
            bus.spi_sclk = 1'b1;
            cyc(4);
        end
    endtask

    task automatic fill(input int pattern);
        logic [7:0] s;
        s = 8'h00;
        for (int k = 0; k < NB + 2; k++) img[k] = 8'($urandom_range(0, 255));
        if (pattern == 0) begin
            for (int k = 0; k < NB; k++) img[k] = 8'h00;
            img[0] = 8'h50;
            img[1] = 8'h81;
            img[2] = 8'h90;
        end
        for (int k = 0; k < NB; k++) s = s + img[k];
        img[NB] = 8'h00 - s;
    endtask

    function automatic bit model_ok(input int nbytes);
        logic [7:0] s;
        s = 8'h00;
        if (nbytes < FL) return 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
        for (int k = 0; k <= NB; k++) s = s + img[k];
`endif
        return s == 8'h00;
    endfunction

    task automatic apply_frame(input string tag, input int nbytes, input int nbits, input int exp_wr,
                               input bit exp_done, input bit exp_err, input int exp_cnt);
        int bad;
        int n;
        wr_addr_q.delete();
        wr_data_q.delete();
        bus.spi_sclk = 1'b0;
        bus.spi_cs_n = 1'b0;
        if (m_done) begin
            n = 0;
            while (n < SS + 2 && bus.cpu_run_n !== 1'b0) begin
                cyc(1);
                n++;
            end
            check({tag, " reload_run_n"}, 32'(bus.cpu_run_n), 32'd0);
        end
        cyc(4);
        for (int k = 0; k < nbytes; k++) send_bits(img[k], 8);
        if (nbits > 0) send_bits(img[nbytes], nbits);
        bus.spi_sclk = 1'b0;
        cyc(4);
        bus.spi_cs_n = 1'b1;
        cyc(8);
        bad = 0;
        for (int k = 0; k < wr_addr_q.size(); k++)
            if (wr_addr_q[k] != k || wr_data_q[k] != int'(img[k])) bad++;
        check({tag, " writes"}, 32'(wr_addr_q.size()), 32'(exp_wr));
        check({tag, " bad_writes"}, 32'(bad), 32'd0);
        check({tag, " done"}, 32'(bus.load_done), 32'(exp_done));
        check({tag, " err"}, 32'(bus.load_err), 32'(exp_err));
        check({tag, " run_n"}, 32'(bus.cpu_run_n), 32'(exp_done));
        check({tag, " byte_cnt"}, 32'(bus.byte_cnt), 32'(exp_cnt));
        check({tag, " load_ram_idle"}, 32'(bus.load_ram), 32'd0);
        m_done = exp_done;
        m_err  = exp_err;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " load_ram"}, 32'(bus.load_ram), 32'd0);
        check({tag, " load_addr"}, 32'(bus.load_addr), 32'd0);
        check({tag, " load_data"}, 32'(bus.load_data), 32'd0);
        check({tag, " cpu_run_n"}, 32'(bus.cpu_run_n), 32'd0);
        check({tag, " load_done"}, 32'(bus.load_done), 32'd0);
        check({tag, " load_err"}, 32'(bus.load_err), 32'd0);
        check({tag, " byte_cnt"}, 32'(bus.byte_cnt), 32'd0);
    endtask

    initial begin
        vec_t vecs [8];
        int   bad;
        vecs[0] = '{FL, 0, 0, NB, 1'b1, 1'b0, NB};
        vecs[1] = '{5,  3, 1, 5,  1'b0, 1'b1, 0};
        vecs[2] = '{FL, 0, 1, NB, 1'b1, 1'b1, NB};
        vecs[3] = '{FL, 0, 1, NB, 1'b1, 1'b0, NB};
        vecs[4] = '{0,  0, 1, 0,  1'b0, 1'b1, 0};
        vecs[5] = '{15, 7, 1, 15, 1'b0, 1'b1, 0};
        vecs[6] = '{FL, 0, 1, NB, 1'b1, 1'b1, NB};
        vecs[7] = '{FL, 5, 1, NB, 1'b1, 1'b0, NB};

        bus.spi_sclk = 1'b0;
        bus.spi_mosi = 1'b0;
        bus.spi_cs_n = 1'b1;
        cyc(3);
        check_reset_outputs("por");
        cpu_reset = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            cyc(1);
            if (bus.cpu_run_n !== 1'b0 || bus.load_ram !== 1'b0) bad++;
        end
        check("idle_100_cycles", 32'(bad), 32'd0);

        for (int v = 0; v < 8; v++) begin
            fill(vecs[v].pattern);
            apply_frame($sformatf("vec%0d", v), vecs[v].nbytes, vecs[v].nbits, vecs[v].exp_wr,
                        vecs[v].exp_done, vecs[v].exp_err, vecs[v].exp_cnt);
        end

        // sclk and cs_n rise together on the 8th bit of byte 2: the bit is dropped
        fill(1);
        wr_addr_q.delete();
        wr_data_q.delete();
        bus.spi_cs_n = 1'b0;
        cyc(8);
        send_bits(img[0], 8);
        send_bits(img[1], 8);
        send_bits(img[2], 7);
        bus.spi_sclk = 1'b0;
        bus.spi_mosi = 1'b1;
        cyc(4);
        bus.spi_sclk = 1'b1;
        bus.spi_cs_n = 1'b1;
        cyc(8);
        bus.spi_sclk = 1'b0;
        cyc(4);
        check("simul writes", 32'(wr_addr_q.size()), 32'd2);
        check("simul err", 32'(bus.load_err), 32'd1);
        check("simul done", 32'(bus.load_done), 32'd0);
        check("simul byte_cnt", 32'(bus.byte_cnt), 32'd0);
        m_done = 1'b0;
        m_err  = 1'b1;

        // cpu_reset during byte 7 of a frame
        fill(1);
        wr_addr_q.delete();
        wr_data_q.delete();
        bus.spi_cs_n = 1'b0;
        cyc(4);
        for (int k = 0; k < 6; k++) send_bits(img[k], 8);
        send_bits(img[6], 3);
        check("midreset writes_before", 32'(wr_addr_q.size()), 32'd6);
        cpu_reset = 1'b0;
        bus.spi_cs_n = 1'b1;
        cyc(1);
        check_reset_outputs("midreset");
        cyc(3);
        cpu_reset = 1'b1;
        wr_addr_q.delete();
        wr_data_q.delete();
        for (int k = 0; k < 8; k++) begin
            bus.spi_sclk = 1'b0;
            cyc(4);
            bus.spi_sclk = 1'b1;
            cyc(4);
        end
        bus.spi_sclk = 1'b0;
        cyc(4);
        check("midreset no_writes", 32'(wr_addr_q.size()), 32'd0);
        check("midreset run_n", 32'(bus.cpu_run_n), 32'd0);
        m_done = 1'b0;
        m_err  = 1'b0;

        for (int r = 0; r < 8; r++) begin
            int nb;
            int nbits;
            bit ok;
            fill(1);
            if ($urandom_range(0, 2) != 0) begin
                nb = FL;
                nbits = 0;
            end else begin
                nb = $urandom_range(0, FL - 1);
                nbits = $urandom_range(0, 7);
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            if (nb == FL && $urandom_range(0, 3) == 0) img[NB] = img[NB] + 8'd1;
`endif
            ok = model_ok(nb);
            apply_frame($sformatf("rand%0d", r), nb, nbits, (nb < NB) ? nb : NB, ok,
                        ok ? (m_done ? 1'b0 : m_err) : 1'b1, ok ? NB : 0);
        end

`ifdef PROG_LOADER_CHECKSUM_EN
        for (int k = 0; k < NB; k++) img[k] = 8'h01;
        img[NB] = 8'hF0;
        apply_frame("csum_good", FL, 0, NB, 1'b1, m_done ? 1'b0 : m_err, NB);
        img[NB] = 8'hF1;
        apply_frame("csum_bad", FL, 0, NB, 1'b0, 1'b1, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
